// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared defines, state/index constants and grant decode for bus_arbiter (optional feature macro: BUS_ARB_TIMEOUT_EN)
`ifndef BUS_ARBITER_DEFINES_SV
`define BUS_ARBITER_DEFINES_SV
`define ADDR_WIDTH    32
`define DATA_WIDTH    32
`define REQ_ENABLE    1'b0
`define REQ_DISABLE   1'b1
`define GRANT_ENABLE  1'b0
`define GRANT_DISABLE 1'b1
`define STATE_IDLE    1'b0
`define STATE_BUSY    1'b1
`define MASTER0       2'd0
`define MASTER1       2'd1
`define MASTER2       2'd2
`define MASTER3       2'd3
`endif

package bus_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = `STATE_IDLE,
        ST_BUSY = `STATE_BUSY
    } state_t;

    localparam logic [1:0] MASTER0 = `MASTER0;
    localparam int         NUM_MASTERS = 4;

    // One grant enabled (the indexed master), all others disabled.
    function automatic logic [3:0] grant_decode(input logic [1:0] idx);
        logic [3:0] g;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            g[i] = (idx == 2'(i)) ? `GRANT_ENABLE : `GRANT_DISABLE;
        end
        return g;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/grant/owner bundle between the masters and bus_arbiter
interface bus_arbiter_if;
    logic       m0_req_;
    logic       m1_req_;
    logic       m2_req_;
    logic       m3_req_;
    logic       m0_grant_;
    logic       m1_grant_;
    logic       m2_grant_;
    logic       m3_grant_;
    logic [1:0] owner;

    modport master (
        output m0_req_, m1_req_, m2_req_, m3_req_,
        input  m0_grant_, m1_grant_, m2_grant_, m3_grant_, owner
    );

    modport slave (
        input  m0_req_, m1_req_, m2_req_, m3_req_,
        output m0_grant_, m1_grant_, m2_grant_, m3_grant_, owner
    );
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// rtl/bus_arbiter_rr_pick.sv - combinational round-robin search for the next bus owner
module bus_arbiter_rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic [1:0] owner,
    input  logic [3:0] req,
    output logic [1:0] next_owner,
    output logic       found
);

    // Scan owner+1, owner+2, owner+3, then owner itself; 2-bit add wraps 3->0.
    always_comb begin
        logic [1:0] cand;
        next_owner = owner;
        found      = 1'b0;
        cand       = owner;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = owner + 2'(k);
            if (!found && req[cand]) begin
                next_owner = cand;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - 4-master round-robin bus arbiter with parking (optional ownership timeout: BUS_ARB_TIMEOUT_EN)
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);

    logic [3:0] req;
    logic [1:0] owner;
    logic [1:0] owner_nxt;
    state_t     state;
    state_t     state_nxt;
    logic [3:0] grant_q;
    logic [1:0] pick_owner;
    logic       pick_found;
    logic       owner_req;
    logic       others_req;
    logic       tmo_hit;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    assign req = {bus.m3_req_ == `REQ_ENABLE, bus.m2_req_ == `REQ_ENABLE,
                  bus.m1_req_ == `REQ_ENABLE, bus.m0_req_ == `REQ_ENABLE};

    assign owner_req  = req[owner];
    assign others_req = |(req & ~(4'b0001 << owner));

    bus_arbiter_rr_pick u_rr_pick (
        .owner      (owner),
        .req        (req),
        .next_owner (pick_owner),
        .found      (pick_found)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;

    assign tmo_hit = (state == ST_BUSY) && others_req && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Count contended BUSY cycles; any ownership change or lull in contention restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (owner_nxt != owner || !others_req || state != ST_BUSY) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Ownership only moves on release (or forced rotation); with no requester the bus parks.
    always_comb begin
        owner_nxt = owner;
        if ((!owner_req || tmo_hit) && pick_found) begin
            owner_nxt = pick_owner;
        end
        state_nxt = (owner_req || pick_found) ? ST_BUSY : ST_IDLE;
    end

    // FSM, owner and registered grant decode share one register stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner   <= MASTER0;
            state   <= ST_IDLE;
            grant_q <= grant_decode(MASTER0);
        end else begin
            owner   <= owner_nxt;
            state   <= state_nxt;
            grant_q <= grant_decode(owner_nxt);
        end
    end

    assign bus.owner     = owner;
    assign bus.m0_grant_ = grant_q[0];
    assign bus.m1_grant_ = grant_q[1];
    assign bus.m2_grant_ = grant_q[2];
    assign bus.m3_grant_ = grant_q[3];

endmodule
